// File: rtl/seq_mult_if.sv
// seq_mult_if: start/operand/result bundle between a multiplier client and seq_mult.
// The client side drives start, a and b; the multiplier returns ready, busy, done
// and the registered product.
interface seq_mult_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   ready;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start, a, b,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, product
  );
endinterface

// File: rtl/seq_mult.sv
// seq_mult: multi-cycle WIDTH x WIDTH multiplier built around a single
// (WIDTH+1)-bit adder/subtractor that is used once per clock.
//
// Build option (macro BOOTH_SIGNED_EN):
//   defined   - two's complement operands and product, radix-2 Booth recoding.
//   undefined - unsigned operands and product, plain shift-add.
// Latency and handshake are identical in both builds: the operation is accepted
// on edge E0, product is written on edge E_WIDTH, and done pulses for one cycle.
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_mult_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             state;
  logic [WIDTH-1:0]       m_reg;
  logic [WIDTH-1:0]       q_reg;
  logic signed [WIDTH:0]  acc;
  logic [CW-1:0]          cnt;
  logic [2*WIDTH-1:0]     prod;

  logic signed [WIDTH:0]  addend;
  logic                   cin;
  logic signed [WIDTH:0]  sum;
  logic signed [WIDTH:0]  acc_nx;
  logic [WIDTH-1:0]       q_nx;

`ifdef BOOTH_SIGNED_EN
  logic                   q_1;
  logic                   q1_nx;
`endif

  assign bus.ready   = (state == S_IDLE);
  assign bus.busy    = (state == S_CALC);
  assign bus.done    = (state == S_DONE);
  assign bus.product = prod;

  // One iteration: select the addend, run the shared adder, then shift right by one.
  always_comb begin
    addend = '0;
    cin    = 1'b0;
`ifdef BOOTH_SIGNED_EN
    q1_nx  = q_reg[0];
    case ({q_reg[0], q_1})
      2'b01:   addend = $signed({m_reg[WIDTH-1], m_reg});
      // Subtract as add of the inverted sign-extended multiplicand plus carry-in.
      2'b10: begin
        addend = $signed(~{m_reg[WIDTH-1], m_reg});
        cin    = 1'b1;
      end
      default: addend = '0;
    endcase
`else
    if (q_reg[0]) begin
      addend = $signed({1'b0, m_reg});
    end
`endif
    sum = acc + addend + $signed({{WIDTH{1'b0}}, cin});
`ifdef BOOTH_SIGNED_EN
    // Arithmetic shift keeps the sign guard of the (WIDTH+1)-bit accumulator.
    acc_nx = sum >>> 1;
`else
    acc_nx = $signed({1'b0, sum[WIDTH:1]});
`endif
    q_nx = {sum[0], q_reg[WIDTH-1:1]};
  end

  // Control FSM plus operand/accumulator/product registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      m_reg <= '0;
      q_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      prod  <= '0;
`ifdef BOOTH_SIGNED_EN
      q_1   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            m_reg <= bus.a;
            q_reg <= bus.b;
            acc   <= '0;
            cnt   <= CW'(WIDTH);
`ifdef BOOTH_SIGNED_EN
            q_1   <= 1'b0;
`endif
            state <= S_CALC;
          end
        end
        S_CALC: begin
          acc   <= acc_nx;
          q_reg <= q_nx;
`ifdef BOOTH_SIGNED_EN
          q_1   <= q1_nx;
`endif
          cnt   <= cnt - CW'(1);
          // Last iteration: the post-shift {acc, Q} is the exact product.
          if (cnt == CW'(1)) begin
            prod  <= {acc_nx[WIDTH-1:0], q_nx};
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: self-checking bench for seq_mult (WIDTH=8 main instance, WIDTH=4
// instance for the narrow zero-operand case). Expected values follow the build
// option BOOTH_SIGNED_EN: signed products when defined, unsigned otherwise.
module tb_seq_mult;

  logic clk = 1'b0;
  logic rst_n;

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  seq_mult_if #(.WIDTH(8)) i8 ();
  seq_mult_if #(.WIDTH(4)) i4 ();

  seq_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(i8));
  seq_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(i4));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: the mathematical product of the operands, truncated to 16 bits.
  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y);
    longint p;
`ifdef BOOTH_SIGNED_EN
    p = longint'($signed(x)) * longint'($signed(y));
`else
    p = longint'(x) * longint'(y);
`endif
    return p[15:0];
  endfunction

  // Run one operation on the 8-bit instance; returns product and accept-to-done latency.
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib,
                     output logic [15:0] prod, output int lat);
    int g;
    @(negedge clk);
    i8.a = ia;
    i8.b = ib;
    i8.start = 1'b1;
    g = 0;
    while (!i8.ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    i8.start = 1'b0;
    chk("op_busy", 64'(i8.busy), 64'd1);
    lat = 0;
    while (!i8.done && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    prod = i8.product;
    @(negedge clk);
    chk("op_done_width", 64'(i8.done), 64'd0);
    chk("op_ready_back", 64'(i8.ready), 64'd1);
  endtask

  initial begin
    logic [15:0] p;
    int          lat;
    int          n;
    logic [7:0]  ra, rb;
    logic        seen_done, seen_busy, prevb;
    int          rises[$];
    logic [15:0] prods[$];
    logic [7:0]  w4p;

`ifdef BOOTH_SIGNED_EN
    vecs[0] = '{8'hFF, 8'hFF, 16'h0001};
    vecs[1] = '{8'h80, 8'h80, 16'h4000};
    vecs[2] = '{8'hFD, 8'h05, 16'hFFF1};
    vecs[3] = '{8'h80, 8'h7F, 16'hC080};
    vecs[4] = '{8'h01, 8'hFF, 16'hFFFF};
    vecs[5] = '{8'h00, 8'h55, 16'h0000};
    vecs[6] = '{8'h07, 8'h09, 16'h003F};
    vecs[7] = '{8'h7F, 8'h7F, 16'h3F01};
    w4p = 8'h01;
`else
    vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{8'h80, 8'h80, 16'h4000};
    vecs[2] = '{8'hFD, 8'h05, 16'h04F1};
    vecs[3] = '{8'h80, 8'h7F, 16'h3F80};
    vecs[4] = '{8'h01, 8'hFF, 16'h00FF};
    vecs[5] = '{8'h00, 8'h55, 16'h0000};
    vecs[6] = '{8'h07, 8'h09, 16'h003F};
    vecs[7] = '{8'h7F, 8'h7F, 16'h3F01};
    w4p = 8'hE1;
`endif

    i8.start = 1'b0; i8.a = '0; i8.b = '0;
    i4.start = 1'b0; i4.a = '0; i4.b = '0;

    // Reset
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready8", 64'(i8.ready), 64'd1);
    chk("rst_busy8", 64'(i8.busy), 64'd0);
    chk("rst_done8", 64'(i8.done), 64'd0);
    chk("rst_prod8", 64'(i8.product), 64'd0);
    chk("rst_ready4", 64'(i4.ready), 64'd1);
    chk("rst_busy4", 64'(i4.busy), 64'd0);
    chk("rst_done4", 64'(i4.done), 64'd0);
    chk("rst_prod4", 64'(i4.product), 64'd0);

    // WIDTH=4: zero operand, then all-ones operands
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      i4.a = (k == 0) ? 4'b0110 : 4'b1111;
      i4.b = (k == 0) ? 4'b0000 : 4'b1111;
      i4.start = 1'b1;
      @(negedge clk);
      i4.start = 1'b0;
      n = 0;
      while (!i4.done && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("w4_latency", 64'(n), 64'd4);
      chk("w4_product", 64'(i4.product), (k == 0) ? 64'd0 : 64'(w4p));
      @(negedge clk);
      chk("w4_done_width", 64'(i4.done), 64'd0);
    end

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      op8(vecs[i].a, vecs[i].b, p, lat);
      chk($sformatf("vec%0d_product", i), 64'(p), 64'(vecs[i].p));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd8);
    end

    // Random operands against the arithmetic reference
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      op8(ra, rb, p, lat);
      chk($sformatf("rand%0d_%0h_%0h", i, ra, rb), 64'(p), 64'(ref8(ra, rb)));
    end

    // Requests during CALC and DONE are ignored
    @(negedge clk);
    i8.a = 8'h0D; i8.b = 8'h0B; i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    repeat (3) @(negedge clk);
    i8.a = 8'h55; i8.b = 8'h33; i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    n = 0;
    while (!i8.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ign_first_product", 64'(i8.product), 64'h008F);
    i8.a = 8'h22; i8.b = 8'h44; i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (i8.done) seen_done = 1'b1;
      if (i8.busy) seen_busy = 1'b1;
    end
    chk("ign_no_second_done", 64'(seen_done), 64'd0);
    chk("ign_no_second_busy", 64'(seen_busy), 64'd0);
    chk("ign_product_held", 64'(i8.product), 64'h008F);

    // Back-to-back with start held high
    @(negedge clk);
    i8.a = 8'd7; i8.b = 8'd9; i8.start = 1'b1;
    prevb = i8.busy;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (i8.busy && !prevb) begin
        rises.push_back(c);
        if (rises.size() == 1) begin
          i8.a = 8'd12; i8.b = 8'd12;
        end else begin
          i8.start = 1'b0;
        end
      end
      if (i8.done) prods.push_back(i8.product);
      prevb = i8.busy;
    end
    i8.start = 1'b0;
    chk("b2b_accepts", 64'(rises.size()), 64'd2);
    chk("b2b_spacing", (rises.size() >= 2) ? 64'(rises[1] - rises[0]) : 64'hDEAD, 64'd10);
    chk("b2b_results", 64'(prods.size()), 64'd2);
    chk("b2b_first", (prods.size() >= 1) ? 64'(prods[0]) : 64'hDEAD, 64'd63);
    chk("b2b_second", (prods.size() >= 2) ? 64'(prods[1]) : 64'hDEAD, 64'd144);

    // Asynchronous reset during the 4th CALC cycle
    @(negedge clk);
    i8.a = 8'hAB; i8.b = 8'hCD; i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(i8.ready), 64'd1);
    chk("mid_rst_busy", 64'(i8.busy), 64'd0);
    chk("mid_rst_done", 64'(i8.done), 64'd0);
    chk("mid_rst_product", 64'(i8.product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (i8.done) seen_done = 1'b1;
    end
    chk("mid_rst_no_done", 64'(seen_done), 64'd0);
    op8(8'd3, 8'd4, p, lat);
    chk("post_rst_product", 64'(p), 64'd12);
    chk("post_rst_latency", 64'(lat), 64'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
